seg14_scan_capture: RTL and testbench
=====================================

// Module: seg14_scan_capture
// PURPOSE
//  Receive end of the 12-digit multiplexed 14-segment display bus: samples one-hot digit select + segment pattern,
//  decodes each glyph to a 4-bit char code, assembles a 12-char frame, hands it to a consumer via valid/ack.
//  Sits on the loopback/self-test path behind the display driver; checks sel sequencing and glyph legality.
// PARAMETERS
//  NUM_DIGITS  12  digits per frame (sel width); index width = $clog2(NUM_DIGITS)
//  SEG_W       14  segment bus width
//  CODE_W      4   decoded char code width
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  scan_valid   in   1        qualifies scan_sel/scan_segm this cycle
//  scan_sel     in   12       one-hot digit select, bit0 = leftmost digit
//  scan_segm    in   14       segment pattern for selected digit
//  frame_valid  out  1        completed frame held in output buffer
//  frame_ack    in   1        consumer releases output buffer
//  rd_addr      in   4        digit index 0..11 into output buffer
//  rd_char      out  4        char code at rd_addr (comb. read); addr>=12 -> 4'hF
//  frame_bad    out  1        delivered frame contains >=1 unknown glyph
//  frame_chg    out  1        delivered frame differs from previously delivered frame
//  frame_cnt    out  8        frames delivered, wraps 255->0
//  err_sel      out  1        sticky: illegal/non-sequential select seen
//  err_ovr      out  1        sticky: frame completed while frame_valid=1 and no ack
//  clr_err      in   1        synchronous clear of err_sel, err_ovr
// BEHAVIOUR
//  Reset: frame_valid=0, frame_bad=0, frame_chg=0, frame_cnt=0, err_sel=0, err_ovr=0, buffers=0 (space), state=HUNT.
//  Input stage: scan_* registered once when scan_valid=1; decode acts on registered copy (1-cycle sample latency).
//  Glyph table (code<-pattern): 0 space 14'h0000, 1 A 3BC0, 2 D 3C12, 3 E 2780, 4 H 1BC0, 5 N 1B24,
//   6 R 33C4, 7 Z 2409, 8 '2' 36C0, 9 '3' 3C40; any other pattern -> code 4'hF, sets frame-local bad bit.
//  sel decode: exactly one bit set -> index; zero or multi-hot -> illegal.
//  FSM HUNT: wait for sel==bit0; then write digit0 into shadow, clear bad bit, go CAPT (expect=1).
//  FSM CAPT: index==last stored index -> ignore (digit hold); index==expect -> store, expect++;
//   illegal or any other index -> err_sel=1, discard shadow, go HUNT (sel==bit0 restarts immediately, same cycle).
//   storing index NUM_DIGITS-1 -> frame complete, go HUNT.
//  Frame complete: if frame_valid=0 or frame_ack=1 same cycle -> shadow copied to output buffer next edge,
//   frame_valid=1, frame_bad=shadow bad bit, frame_chg=(new!=old buffer), frame_cnt++.
//   else -> err_ovr=1, frame dropped, output buffer untouched.
//  frame_ack with frame_valid=1 -> frame_valid=0 next edge; buffer content retained for rd_addr reads.
//  Total latency: sel bit11 sample at cycle N -> frame_valid high at edge N+2.
//  clr_err same cycle as new error -> error wins (flag stays 1).
//  rst_n asserted mid-frame: everything to reset values immediately, shadow discarded.
// STRUCTURE
//  Shared package seg14_pkg: SEG_W/NUM_DIGITS constants, glyph pattern localparams, char code localparams,
//   FSM state encoding (HUNT, CAPT).
//  Sub-module seg14_glyph_decode: combinational pattern->code + unknown flag; reused by future display checkers.
//  Top holds input reg, one-hot decoder, FSM, shadow + output buffers (12 x 4 each), compare, counters.
// TESTING
//  1 Driver sequence H E R N A N D E Z sp 2 3, one digit/cycle -> frame_valid at +2, rd_char 0..11 = 4,3,6,5,1,5,2,3,7,0,8,9, bad=0.
//  2 Same frame repeated, each digit held 3 cycles -> identical frame, frame_chg=0, frame_cnt=2, no errors.
//  3 Digit 5 segm=14'h3FFF -> frame_bad=1, rd_char(5)=F, others correct.
//  4 sel 12'h003 at digit1, then skip digit4 in next frame -> err_sel=1, both frames dropped, recovers on next bit0.
//  5 Two full frames with no frame_ack -> err_ovr=1, buffer holds frame 1; clr_err -> err_ovr=0.
//  6 rst_n low at digit 7 -> outputs reset async; next clean frame delivered with frame_cnt=1.

Source files
------------

// File: rtl/seg14_pkg.sv
// Shared constants, glyph table and types for the 14-segment scan capture path.
package seg14_pkg;

   localparam int NUM_DIGITS = 12;
   localparam int SEG_W      = 14;
   localparam int CODE_W     = 4;
   localparam int IDX_W      = $clog2(NUM_DIGITS);

   localparam logic [SEG_W-1:0] GLY_SP = 14'h0000;
   localparam logic [SEG_W-1:0] GLY_A  = 14'h3BC0;
   localparam logic [SEG_W-1:0] GLY_D  = 14'h3C12;
   localparam logic [SEG_W-1:0] GLY_E  = 14'h2780;
   localparam logic [SEG_W-1:0] GLY_H  = 14'h1BC0;
   localparam logic [SEG_W-1:0] GLY_N  = 14'h1B24;
   localparam logic [SEG_W-1:0] GLY_R  = 14'h33C4;
   localparam logic [SEG_W-1:0] GLY_Z  = 14'h2409;
   localparam logic [SEG_W-1:0] GLY_2  = 14'h36C0;
   localparam logic [SEG_W-1:0] GLY_3  = 14'h3C40;

   localparam logic [CODE_W-1:0] CH_SP  = 4'd0;
   localparam logic [CODE_W-1:0] CH_A   = 4'd1;
   localparam logic [CODE_W-1:0] CH_D   = 4'd2;
   localparam logic [CODE_W-1:0] CH_E   = 4'd3;
   localparam logic [CODE_W-1:0] CH_H   = 4'd4;
   localparam logic [CODE_W-1:0] CH_N   = 4'd5;
   localparam logic [CODE_W-1:0] CH_R   = 4'd6;
   localparam logic [CODE_W-1:0] CH_Z   = 4'd7;
   localparam logic [CODE_W-1:0] CH_2   = 4'd8;
   localparam logic [CODE_W-1:0] CH_3   = 4'd9;
   localparam logic [CODE_W-1:0] CH_UNK = 4'hF;

   typedef enum logic {
      HUNT = 1'b0,
      CAPT = 1'b1
   } state_e;

   typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] frame_t;

endpackage

// File: rtl/seg14_glyph_decode.sv
// Combinational 14-segment pattern to char code lookup.
// Patterns outside the table return CH_UNK with unk raised.
module seg14_glyph_decode
   import seg14_pkg::*;
(
   input  logic [SEG_W-1:0]  segm,
   output logic [CODE_W-1:0] code,
   output logic              unk
);

   always_comb begin
      code = CH_UNK;
      unk  = 1'b0;
      unique case (segm)
         GLY_SP:  code = CH_SP;
         GLY_A:   code = CH_A;
         GLY_D:   code = CH_D;
         GLY_E:   code = CH_E;
         GLY_H:   code = CH_H;
         GLY_N:   code = CH_N;
         GLY_R:   code = CH_R;
         GLY_Z:   code = CH_Z;
         GLY_2:   code = CH_2;
         GLY_3:   code = CH_3;
         default: unk  = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg14_scan_capture.sv
// Receive side of the 12-digit multiplexed 14-segment bus: samples,
// decodes and assembles frames, handing them out through valid/ack.
module seg14_scan_capture
   import seg14_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scan_valid,
   input  logic [NUM_DIGITS-1:0] scan_sel,
   input  logic [SEG_W-1:0]      scan_segm,
   output logic                  frame_valid,
   input  logic                  frame_ack,
   input  logic [IDX_W-1:0]      rd_addr,
   output logic [CODE_W-1:0]     rd_char,
   output logic                  frame_bad,
   output logic                  frame_chg,
   output logic [7:0]            frame_cnt,
   output logic                  err_sel,
   output logic                  err_ovr,
   input  logic                  clr_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   logic                  s_vld_q, s_vld_d;
   logic [NUM_DIGITS-1:0] s_sel_q, s_sel_d;
   logic [SEG_W-1:0]      s_segm_q, s_segm_d;

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      exp_q, exp_d;
   logic [IDX_W-1:0]      last_q, last_d;
   frame_t                shd_q, shd_d;
   logic                  sbad_q, sbad_d;

   frame_t                obuf_q, obuf_d;
   logic                  fv_q, fv_d;
   logic                  fbad_q, fbad_d;
   logic                  fchg_q, fchg_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  esel_q, esel_d;
   logic                  eovr_q, eovr_d;

   logic [IDX_W-1:0]      sel_idx;
   logic                  sel_ok;
   logic [CODE_W-1:0]     g_code;
   logic                  g_unk;
   logic                  start;
   logic                  done;
   logic                  sel_err;

   seg14_glyph_decode u_glyph (
      .segm (s_segm_q),
      .code (g_code),
      .unk  (g_unk)
   );

   always_comb begin
      s_vld_d  = scan_valid;
      s_sel_d  = scan_valid ? scan_sel  : s_sel_q;
      s_segm_d = scan_valid ? scan_segm : s_segm_q;
   end

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (s_sel_q[i]) sel_idx = IDX_W'(i);
      end
   end

   assign sel_ok = ($countones(s_sel_q) == 1);
   assign start  = s_vld_q && sel_ok && (sel_idx == '0);

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      last_d  = last_q;
      shd_d   = shd_q;
      sbad_d  = sbad_q;
      done    = 1'b0;
      sel_err = 1'b0;
      unique case (state_q)
         HUNT: begin
            if (start) begin
               shd_d[0] = g_code;
               sbad_d   = g_unk;
               last_d   = '0;
               exp_d    = ONE_IDX;
               state_d  = CAPT;
            end
         end
         CAPT: begin
            // a repeated sample of the last stored digit is a display hold
            if (s_vld_q && !(sel_ok && sel_idx == last_q)) begin
               if (sel_ok && sel_idx == exp_q) begin
                  shd_d[sel_idx] = g_code;
                  sbad_d         = sbad_q | g_unk;
                  last_d         = sel_idx;
                  exp_d          = exp_q + ONE_IDX;
                  if (sel_idx == LAST_IDX) begin
                     done    = 1'b1;
                     state_d = HUNT;
                  end
               end else begin
                  sel_err = 1'b1;
                  state_d = HUNT;
                  if (start) begin
                     shd_d[0] = g_code;
                     sbad_d   = g_unk;
                     last_d   = '0;
                     exp_d    = ONE_IDX;
                     state_d  = CAPT;
                  end
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_comb begin
      obuf_d = obuf_q;
      fv_d   = fv_q;
      fbad_d = fbad_q;
      fchg_d = fchg_q;
      cnt_d  = cnt_q;
      esel_d = clr_err ? 1'b0 : esel_q;
      eovr_d = clr_err ? 1'b0 : eovr_q;
      if (sel_err) esel_d = 1'b1;
      if (done) begin
         if (!fv_q || frame_ack) begin
            obuf_d = shd_d;
            fv_d   = 1'b1;
            fbad_d = sbad_d;
            fchg_d = (shd_d != obuf_q);
            cnt_d  = cnt_q + 8'd1;
         end else begin
            eovr_d = 1'b1;
         end
      end else if (fv_q && frame_ack) begin
         fv_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_vld_q  <= 1'b0;
         s_sel_q  <= '0;
         s_segm_q <= '0;
         state_q  <= HUNT;
         exp_q    <= '0;
         last_q   <= '0;
         shd_q    <= '0;
         sbad_q   <= 1'b0;
         obuf_q   <= '0;
         fv_q     <= 1'b0;
         fbad_q   <= 1'b0;
         fchg_q   <= 1'b0;
         cnt_q    <= '0;
         esel_q   <= 1'b0;
         eovr_q   <= 1'b0;
      end else begin
         s_vld_q  <= s_vld_d;
         s_sel_q  <= s_sel_d;
         s_segm_q <= s_segm_d;
         state_q  <= state_d;
         exp_q    <= exp_d;
         last_q   <= last_d;
         shd_q    <= shd_d;
         sbad_q   <= sbad_d;
         obuf_q   <= obuf_d;
         fv_q     <= fv_d;
         fbad_q   <= fbad_d;
         fchg_q   <= fchg_d;
         cnt_q    <= cnt_d;
         esel_q   <= esel_d;
         eovr_q   <= eovr_d;
      end
   end

   assign rd_char     = (rd_addr < IDX_W'(NUM_DIGITS)) ? obuf_q[rd_addr] : CH_UNK;
   assign frame_valid = fv_q;
   assign frame_bad   = fbad_q;
   assign frame_chg   = fchg_q;
   assign frame_cnt   = cnt_q;
   assign err_sel     = esel_q;
   assign err_ovr     = eovr_q;

endmodule

// File: tb/tb_seg14_scan_capture.sv
// Scenario bench for seg14_scan_capture with a frame-level reference model.
module tb_seg14_scan_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_valid = 1'b0;
   logic [11:0] scan_sel = '0;
   logic [13:0] scan_segm = '0;
   logic        frame_ack = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic        clr_err = 1'b0;
   logic        frame_valid, frame_bad, frame_chg;
   logic [7:0]  frame_cnt;
   logic        err_sel, err_ovr;
   logic [3:0]  rd_char;

   int checks = 0;
   int errors = 0;

   seg14_scan_capture dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .scan_valid  (scan_valid),
      .scan_sel    (scan_sel),
      .scan_segm   (scan_segm),
      .frame_valid (frame_valid),
      .frame_ack   (frame_ack),
      .rd_addr     (rd_addr),
      .rd_char     (rd_char),
      .frame_bad   (frame_bad),
      .frame_chg   (frame_chg),
      .frame_cnt   (frame_cnt),
      .err_sel     (err_sel),
      .err_ovr     (err_ovr),
      .clr_err     (clr_err)
   );

   always #5 clk = ~clk;

   // glyph table indexed by char code
   logic [13:0] gly [10] = '{14'h0000, 14'h3BC0, 14'h3C12, 14'h2780,
      14'h1BC0, 14'h1B24, 14'h33C4, 14'h2409, 14'h36C0, 14'h3C40};

   logic [13:0] fr [12];
   logic [3:0]  rbuf [12];
   logic [3:0]  m_prev [12];
   int          m_cnt = 0;
   logic [3:0]  e_code [12];
   logic        e_bad, e_chg;
   logic [7:0]  e_cnt;

   function automatic logic [3:0] ref_code(logic [13:0] p);
      for (int i = 0; i < 10; i++) if (gly[i] == p) return 4'(i);
      return 4'hF;
   endfunction

   task automatic model_deliver();
      e_bad = 1'b0;
      e_chg = 1'b0;
      for (int i = 0; i < 12; i++) begin
         e_code[i] = ref_code(fr[i]);
         if (e_code[i] == 4'hF) e_bad = 1'b1;
         if (e_code[i] != m_prev[i]) e_chg = 1'b1;
      end
      for (int i = 0; i < 12; i++) m_prev[i] = e_code[i];
      m_cnt = (m_cnt + 1) % 256;
      e_cnt = 8'(m_cnt);
   endtask

   task automatic model_reset();
      m_cnt = 0;
      for (int i = 0; i < 12; i++) m_prev[i] = 4'h0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(int idx, logic [13:0] p);
      step();
      scan_valid = 1'b1;
      scan_sel = '0;
      scan_sel[idx] = 1'b1;
      scan_segm = p;
   endtask

   task automatic idle(int n);
      repeat (n) begin
         step();
         scan_valid = 1'b0;
      end
   endtask

   task automatic send(int hold, int gap);
      for (int d = 0; d < 12; d++) begin
         repeat (hold) put(d, fr[d]);
         if (gap > 0) idle($urandom_range(0, gap));
      end
      idle(2);
   endtask

   task automatic ack_frame();
      step();
      frame_ack = 1'b1;
      step();
      frame_ack = 1'b0;
   endtask

   task automatic clr_pulse();
      step();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
   endtask

   task automatic read_all();
      for (int i = 0; i < 12; i++) begin
         rd_addr = 4'(i);
         #1;
         rbuf[i] = rd_char;
      end
   endtask

   task automatic rand_frame(int pbad);
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 99) < pbad) fr[i] = 14'($urandom);
         else fr[i] = gly[$urandom_range(0, 9)];
      end
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", frame_valid); end
      checks++; if (frame_bad !== 1'b0) begin errors++; $display("FAIL rst_bad got %b exp 0", frame_bad); end
      checks++; if (frame_chg !== 1'b0) begin errors++; $display("FAIL rst_chg got %b exp 0", frame_chg); end
      checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", frame_cnt); end
      checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL rst_err_sel got %b exp 0", err_sel); end
      checks++; if (err_ovr !== 1'b0) begin errors++; $display("FAIL rst_err_ovr got %b exp 0", err_ovr); end
      read_all();
      for (int i = 0; i < 12; i++) begin
         checks++; if (rbuf[i] !== 4'h0) begin errors++; $display("FAIL rst_char[%0d] got %h exp 0", i, rbuf[i]); end
      end
      for (int a = 12; a < 16; a++) begin
         rd_addr = 4'(a);
         #1;
         checks++; if (rd_char !== 4'hF) begin errors++; $display("FAIL rd_oob[%0d] got %h exp f", a, rd_char); end
      end
   endtask

   task automatic test_basic();
      logic [3:0] want [12] = '{4'd4, 4'd3, 4'd6, 4'd5, 4'd1, 4'd5,
         4'd2, 4'd3, 4'd7, 4'd0, 4'd8, 4'd9};
      fr = '{14'h1BC0, 14'h2780, 14'h33C4, 14'h1B24, 14'h3BC0, 14'h1B24,
         14'h3C12, 14'h2780, 14'h2409, 14'h0000, 14'h36C0, 14'h3C40};
      for (int d = 0; d < 12; d++) put(d, fr[d]);
      idle(1);
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", frame_valid); end
      idle(1);
      model_deliver();
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", frame_valid); end
      checks++; if (frame_bad !== 1'b0) begin errors++; $display("FAIL basic_bad got %b exp 0", frame_bad); end
      checks++; if (frame_chg !== 1'b1) begin errors++; $display("FAIL basic_chg got %b exp 1", frame_chg); end
      checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", frame_cnt); end
      read_all();
      for (int i = 0; i < 12; i++) begin
         checks++; if (rbuf[i] !== want[i]) begin errors++; $display("FAIL basic_char[%0d] got %h exp %h", i, rbuf[i], want[i]); end
      end
      ack_frame();
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_ack got %b exp 0", frame_valid); end
   endtask

   task automatic test_hold();
      send(3, 0);
      model_deliver();
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b exp 1", frame_valid); end
      checks++; if (frame_chg !== 1'b0) begin errors++; $display("FAIL hold_chg got %b exp 0", frame_chg); end
      checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL hold_cnt got %0d exp 2", frame_cnt); end
      checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL hold_err_sel got %b exp 0", err_sel); end
      checks++; if (err_ovr !== 1'b0) begin errors++; $display("FAIL hold_err_ovr got %b exp 0", err_ovr); end
      ack_frame();
   endtask

   task automatic test_bad_glyph();
      logic [13:0] keep;
      keep = fr[5];
      fr[5] = 14'h3FFF;
      send(1, 0);
      model_deliver();
      checks++; if (frame_bad !== 1'b1) begin errors++; $display("FAIL bad_flag got %b exp 1", frame_bad); end
      checks++; if (frame_chg !== e_chg) begin errors++; $display("FAIL bad_chg got %b exp %b", frame_chg, e_chg); end
      checks++; if (frame_cnt !== e_cnt) begin errors++; $display("FAIL bad_cnt got %0d exp %0d", frame_cnt, e_cnt); end
      read_all();
      checks++; if (rbuf[5] !== 4'hF) begin errors++; $display("FAIL bad_char5 got %h exp f", rbuf[5]); end
      for (int i = 0; i < 12; i++) begin
         checks++; if (rbuf[i] !== e_code[i]) begin errors++; $display("FAIL bad_char[%0d] got %h exp %h", i, rbuf[i], e_code[i]); end
      end
      fr[5] = keep;
      ack_frame();
   endtask

   task automatic test_sel_err();
      put(0, fr[0]);
      step();
      scan_valid = 1'b1;
      scan_sel = 12'h003;
      scan_segm = fr[1];
      for (int d = 2; d < 12; d++) put(d, fr[d]);
      idle(2);
      checks++; if (err_sel !== 1'b1) begin errors++; $display("FAIL selerr_multi got %b exp 1", err_sel); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL selerr_valid got %b exp 0", frame_valid); end
      checks++; if (frame_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL selerr_cnt got %0d exp %0d", frame_cnt, m_cnt); end
      for (int d = 0; d < 4; d++) put(d, fr[d]);
      put(5, fr[5]);
      clr_err = 1'b1;
      put(6, fr[6]);
      checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL selerr_clr got %b exp 0", err_sel); end
      put(7, fr[7]);
      clr_err = 1'b0;
      checks++; if (err_sel !== 1'b1) begin errors++; $display("FAIL selerr_skip_wins got %b exp 1", err_sel); end
      for (int d = 8; d < 12; d++) put(d, fr[d]);
      idle(2);
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL selerr_skip_valid got %b exp 0", frame_valid); end
      checks++; if (frame_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL selerr_skip_cnt got %0d exp %0d", frame_cnt, m_cnt); end
      rand_frame(0);
      send(1, 0);
      model_deliver();
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL selerr_recover got %b exp 1", frame_valid); end
      checks++; if (frame_cnt !== e_cnt) begin errors++; $display("FAIL selerr_rec_cnt got %0d exp %0d", frame_cnt, e_cnt); end
      read_all();
      for (int i = 0; i < 12; i++) begin
         checks++; if (rbuf[i] !== e_code[i]) begin errors++; $display("FAIL selerr_char[%0d] got %h exp %h", i, rbuf[i], e_code[i]); end
      end
      clr_pulse();
      checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL selerr_cleared got %b exp 0", err_sel); end
      ack_frame();
   endtask

   task automatic test_overrun();
      rand_frame(10);
      send(1, 1);
      model_deliver();
      checks++; if (frame_cnt !== e_cnt) begin errors++; $display("FAIL ovr_cnt1 got %0d exp %0d", frame_cnt, e_cnt); end
      checks++; if (err_ovr !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", err_ovr); end
      rand_frame(10);
      send(1, 1);
      checks++; if (err_ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", err_ovr); end
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", frame_valid); end
      checks++; if (frame_cnt !== e_cnt) begin errors++; $display("FAIL ovr_cnt2 got %0d exp %0d", frame_cnt, e_cnt); end
      checks++; if (frame_bad !== e_bad) begin errors++; $display("FAIL ovr_bad got %b exp %b", frame_bad, e_bad); end
      read_all();
      for (int i = 0; i < 12; i++) begin
         checks++; if (rbuf[i] !== e_code[i]) begin errors++; $display("FAIL ovr_char[%0d] got %h exp %h", i, rbuf[i], e_code[i]); end
      end
      clr_pulse();
      checks++; if (err_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", err_ovr); end
   endtask

   task automatic test_reset_mid();
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b exp 1", frame_valid); end
      rand_frame(0);
      for (int d = 0; d < 8; d++) put(d, fr[d]);
      #2 rst_n = 1'b0;
      scan_valid = 1'b0;
      #1;
      model_reset();
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", frame_valid); end
      checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rmid_cnt got %0d exp 0", frame_cnt); end
      checks++; if (frame_bad !== 1'b0 || frame_chg !== 1'b0) begin errors++; $display("FAIL rmid_flags got %b%b exp 00", frame_bad, frame_chg); end
      read_all();
      for (int i = 0; i < 12; i++) begin
         checks++; if (rbuf[i] !== 4'h0) begin errors++; $display("FAIL rmid_char[%0d] got %h exp 0", i, rbuf[i]); end
      end
      step();
      rst_n = 1'b1;
      for (int d = 8; d < 12; d++) put(d, fr[d]);
      idle(2);
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rmid_partial got %b exp 0", frame_valid); end
      send(1, 0);
      model_deliver();
      checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL rmid_cnt1 got %0d exp 1", frame_cnt); end
      checks++; if (frame_chg !== e_chg) begin errors++; $display("FAIL rmid_chg got %b exp %b", frame_chg, e_chg); end
      read_all();
      for (int i = 0; i < 12; i++) begin
         checks++; if (rbuf[i] !== e_code[i]) begin errors++; $display("FAIL rmid_char2[%0d] got %h exp %h", i, rbuf[i], e_code[i]); end
      end
      ack_frame();
   endtask

   task automatic test_back_to_back();
      frame_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k != 2 || $urandom_range(0, 1) == 0) rand_frame(10);
         for (int d = 0; d < 12; d++) put(d, fr[d]);
         model_deliver();
      end
      idle(2);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", frame_valid); end
      checks++; if (err_ovr !== 1'b0) begin errors++; $display("FAIL b2b_ovr got %b exp 0", err_ovr); end
      checks++; if (frame_cnt !== e_cnt) begin errors++; $display("FAIL b2b_cnt got %0d exp %0d", frame_cnt, e_cnt); end
      checks++; if (frame_chg !== e_chg) begin errors++; $display("FAIL b2b_chg got %b exp %b", frame_chg, e_chg); end
      checks++; if (frame_bad !== e_bad) begin errors++; $display("FAIL b2b_bad got %b exp %b", frame_bad, e_bad); end
      read_all();
      for (int i = 0; i < 12; i++) begin
         checks++; if (rbuf[i] !== e_code[i]) begin errors++; $display("FAIL b2b_char[%0d] got %h exp %h", i, rbuf[i], e_code[i]); end
      end
      frame_ack = 1'b0;
      step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         if ($urandom_range(0, 3) != 0) rand_frame(15);
         send($urandom_range(1, 3), 2);
         model_deliver();
         checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL rnd%0d_valid got %b exp 1", n, frame_valid); end
         checks++; if (frame_bad !== e_bad) begin errors++; $display("FAIL rnd%0d_bad got %b exp %b", n, frame_bad, e_bad); end
         checks++; if (frame_chg !== e_chg) begin errors++; $display("FAIL rnd%0d_chg got %b exp %b", n, frame_chg, e_chg); end
         checks++; if (frame_cnt !== e_cnt) begin errors++; $display("FAIL rnd%0d_cnt got %0d exp %0d", n, frame_cnt, e_cnt); end
         checks++; if (err_sel !== 1'b0 || err_ovr !== 1'b0) begin errors++; $display("FAIL rnd%0d_err got %b%b exp 00", n, err_sel, err_ovr); end
         read_all();
         for (int i = 0; i < 12; i++) begin
            checks++; if (rbuf[i] !== e_code[i]) begin errors++; $display("FAIL rnd%0d_char[%0d] got %h exp %h", n, i, rbuf[i], e_code[i]); end
         end
         ack_frame();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_bad_glyph();
      test_sel_err();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
